// File: rtl/y86_decode_execute_pkg.sv
// Shared Y86-64 encodings, pipeline-register layouts and small decode helpers.
// Combinational helpers only; no state and no backpressure.
package y86_decode_execute_pkg;

    localparam int NIBBLE   = 4;
    localparam int D_WORD   = 64;
    localparam int NUM_REGS = 15;

    typedef logic [NIBBLE-1:0] nib_t;
    typedef logic [D_WORD-1:0] word_t;

    localparam nib_t I_HALT   = 4'h0;
    localparam nib_t I_NOP    = 4'h1;
    localparam nib_t I_RRMOVQ = 4'h2;
    localparam nib_t I_IRMOVQ = 4'h3;
    localparam nib_t I_RMMOVQ = 4'h4;
    localparam nib_t I_MRMOVQ = 4'h5;
    localparam nib_t I_OPQ    = 4'h6;
    localparam nib_t I_JXX    = 4'h7;
    localparam nib_t I_CALL   = 4'h8;
    localparam nib_t I_RET    = 4'h9;
    localparam nib_t I_PUSHQ  = 4'hA;
    localparam nib_t I_POPQ   = 4'hB;

    localparam nib_t R_RSP  = 4'h4;
    localparam nib_t R_NONE = 4'hF;

    localparam nib_t S_AOK = 4'h1;
    localparam nib_t S_HLT = 4'h2;
    localparam nib_t S_ADR = 4'h3;
    localparam nib_t S_INS = 4'h4;

    localparam nib_t A_ADD = 4'h0;
    localparam nib_t A_SUB = 4'h1;
    localparam nib_t A_AND = 4'h2;
    localparam nib_t A_XOR = 4'h3;

    localparam nib_t C_YES = 4'h0;
    localparam nib_t C_LE  = 4'h1;
    localparam nib_t C_L   = 4'h2;
    localparam nib_t C_E   = 4'h3;
    localparam nib_t C_NE  = 4'h4;
    localparam nib_t C_GE  = 4'h5;
    localparam nib_t C_G   = 4'h6;

    typedef struct packed {
        nib_t  stat;
        nib_t  icode;
        nib_t  ifun;
        nib_t  ra;
        nib_t  rb;
        word_t valc;
        word_t valp;
    } d_reg_t;

    typedef struct packed {
        nib_t  stat;
        nib_t  icode;
        nib_t  ifun;
        nib_t  src_a;
        nib_t  src_b;
        nib_t  dst_e;
        nib_t  dst_m;
        word_t valc;
        word_t vala;
        word_t valb;
    } e_reg_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic cond_eval(input nib_t fn, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (fn)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return ~cc.zf;
            C_GE:    return ~lt;
            C_G:     return ~lt & ~cc.zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic stat_blocks_cc(input nib_t s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

    // Youngest producer wins: execute, then memory (load before ALU), then write-back.
    function automatic word_t fwd(input nib_t src, input word_t rf_val,
                                  input nib_t e_dst, input word_t e_val,
                                  input nib_t m_dstm, input word_t m_valm,
                                  input nib_t m_dste, input word_t m_vale,
                                  input nib_t w_dstm, input word_t w_valm,
                                  input nib_t w_dste, input word_t w_vale);
        if (src == R_NONE) return '0;
        if (src == e_dst)  return e_val;
        if (src == m_dstm) return m_valm;
        if (src == m_dste) return m_vale;
        if (src == w_dstm) return w_valm;
        if (src == w_dste) return w_vale;
        return rf_val;
    endfunction

endpackage

// File: rtl/y86_decode_execute_if.sv
// Bundle of fetch inputs, downstream feedback and decode/execute outputs.
// Pure wiring; master drives the stimulus side, slave is the decode/execute block.
interface y86_decode_execute_if #(parameter int W = 64, parameter int N = 4);

    logic [N-1:0] f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i;
    logic [W-1:0] f_valC_i, f_valP_i;
    logic [N-1:0] M_dstE_i, M_dstM_i;
    logic [W-1:0] M_valE_i, m_valM_i;
    logic [N-1:0] W_dstE_i, W_dstM_i;
    logic [W-1:0] W_valE_i, W_valM_i;
    logic [N-1:0] m_stat_i, W_stat_i;

    logic [N-1:0] D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o;
    logic [W-1:0] D_valC_o, D_valP_o;
    logic [N-1:0] d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o;
    logic [W-1:0] d_valA_o, d_valB_o;
    logic [N-1:0] E_stat_o, E_icode_o, E_ifun_o, E_srcA_o, E_srcB_o, E_dstE_o, E_dstM_o;
    logic [W-1:0] E_valC_o, E_valA_o, E_valB_o;
    logic         e_Cnd_o;
    logic [N-1:0] e_dstE_o;
    logic [W-1:0] e_valE_o;

    modport master (
        output f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i, f_valC_i, f_valP_i,
               M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
               W_dstE_i, W_dstM_i, W_valE_i, W_valM_i, m_stat_i, W_stat_i,
        input  D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o, D_valC_o, D_valP_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o,
               E_stat_o, E_icode_o, E_ifun_o, E_srcA_o, E_srcB_o, E_dstE_o, E_dstM_o,
               E_valC_o, E_valA_o, E_valB_o, e_Cnd_o, e_dstE_o, e_valE_o
    );

    modport slave (
        input  f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i, f_valC_i, f_valP_i,
               M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
               W_dstE_i, W_dstM_i, W_valE_i, W_valM_i, m_stat_i, W_stat_i,
        output D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o, D_valC_o, D_valP_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o,
               E_stat_o, E_icode_o, E_ifun_o, E_srcA_o, E_srcB_o, E_dstE_o, E_dstM_o,
               E_valC_o, E_valA_o, E_valB_o, e_Cnd_o, e_dstE_o, e_valE_o
    );

endinterface

// File: rtl/y86_regfile.sv
// 15x64 register file, two combinational read ports, two write ports (M port wins on collision).
// Reads are same-cycle, writes land on the rising edge; no backpressure.
module y86_regfile
    import y86_decode_execute_pkg::*;
(
    input  logic  clk_i,
    input  logic  rstn_i,
    input  nib_t  src_a,
    input  nib_t  src_b,
    output word_t val_a,
    output word_t val_b,
    input  nib_t  dst_e,
    input  word_t val_e,
    input  nib_t  dst_m,
    input  word_t val_m
);

    word_t regs [NUM_REGS];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (dst_e != R_NONE) regs[dst_e] <= val_e;
            if (dst_m != R_NONE) regs[dst_m] <= val_m;
        end
    end

    // ID F is the "no register" code and reads as zero.
    assign val_a = (src_a == R_NONE) ? '0 : regs[src_a];
    assign val_b = (src_b == R_NONE) ? '0 : regs[src_b];

endmodule

// File: rtl/y86_decode_execute.sv
// Y86-64 D register, decode/write-back with forwarding, E register, ALU and condition codes.
// Latency: 1 cycle fetch->decode, 1 more to execute; no stall/bubble, registers load every edge.
module y86_decode_execute
    import y86_decode_execute_pkg::*;
#(
    parameter int W = D_WORD,
    parameter int N = NIBBLE
)
(
    input  logic clk_i,
    input  logic rstn_i,
    y86_decode_execute_if.slave bus
);

    d_reg_t       d_q;
    e_reg_t       e_q;
    cc_t          cc_q;
    nib_t         src_a, src_b, dst_e, dst_m;
    word_t        rf_a, rf_b;
    logic [W-1:0] d_val_a, d_val_b;
    logic [W-1:0] alu_a, alu_b, val_e;
    nib_t         alu_fn;
    logic         alu_of;
    logic         e_cnd;
    logic [N-1:0] e_dst_e;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d_q <= '{stat: S_AOK, icode: I_NOP, ifun: '0, ra: R_NONE, rb: R_NONE,
                     valc: '0, valp: '0};
        end else begin
            d_q <= '{stat: bus.f_stat_i, icode: bus.f_icode_i, ifun: bus.f_ifun_i,
                     ra: bus.f_rA_i, rb: bus.f_rB_i, valc: bus.f_valC_i, valp: bus.f_valP_i};
        end
    end

    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (d_q.icode)
            I_RRMOVQ: begin src_a = d_q.ra; dst_e = d_q.rb; end
            I_IRMOVQ: dst_e = d_q.rb;
            I_RMMOVQ: begin src_a = d_q.ra; src_b = d_q.rb; end
            I_MRMOVQ: begin src_b = d_q.rb; dst_m = d_q.ra; end
            I_OPQ:    begin src_a = d_q.ra; src_b = d_q.rb; dst_e = d_q.rb; end
            I_CALL:   begin src_b = R_RSP; dst_e = R_RSP; end
            I_RET:    begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; end
            I_PUSHQ:  begin src_a = d_q.ra; src_b = R_RSP; dst_e = R_RSP; end
            I_POPQ:   begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; dst_m = d_q.ra; end
            default:  ;
        endcase
    end

    y86_regfile u_regfile (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .src_a  (src_a),
        .src_b  (src_b),
        .val_a  (rf_a),
        .val_b  (rf_b),
        .dst_e  (bus.W_dstE_i),
        .val_e  (bus.W_valE_i),
        .dst_m  (bus.W_dstM_i),
        .val_m  (bus.W_valM_i)
    );

    // CALL/JXX carry the fall-through PC down the valA lane instead of a register.
    always_comb begin
        if (d_q.icode == I_CALL || d_q.icode == I_JXX) begin
            d_val_a = d_q.valp;
        end else begin
            d_val_a = fwd(src_a, rf_a, e_dst_e, val_e,
                          bus.M_dstM_i, bus.m_valM_i, bus.M_dstE_i, bus.M_valE_i,
                          bus.W_dstM_i, bus.W_valM_i, bus.W_dstE_i, bus.W_valE_i);
        end
        d_val_b = fwd(src_b, rf_b, e_dst_e, val_e,
                      bus.M_dstM_i, bus.m_valM_i, bus.M_dstE_i, bus.M_valE_i,
                      bus.W_dstM_i, bus.W_valM_i, bus.W_dstE_i, bus.W_valE_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            e_q <= '{stat: S_AOK, icode: I_NOP, ifun: '0, src_a: R_NONE, src_b: R_NONE,
                     dst_e: R_NONE, dst_m: R_NONE, valc: '0, vala: '0, valb: '0};
        end else begin
            e_q <= '{stat: d_q.stat, icode: d_q.icode, ifun: d_q.ifun, src_a: src_a,
                     src_b: src_b, dst_e: dst_e, dst_m: dst_m, valc: d_q.valc,
                     vala: d_val_a, valb: d_val_b};
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (e_q.icode)
            I_RRMOVQ, I_OPQ:             alu_a = e_q.vala;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.valc;
            I_CALL, I_PUSHQ:             alu_a = ~W'(7);
            I_RET, I_POPQ:               alu_a = W'(8);
            default:                     ;
        endcase
        case (e_q.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = e_q.valb;
            default: ;
        endcase
        alu_fn = (e_q.icode == I_OPQ) ? e_q.ifun : A_ADD;
        val_e  = '0;
        alu_of = 1'b0;
        case (alu_fn)
            A_ADD: begin
                val_e  = alu_b + alu_a;
                alu_of = (alu_a[W-1] == alu_b[W-1]) && (val_e[W-1] != alu_a[W-1]);
            end
            A_SUB: begin
                val_e  = alu_b - alu_a;
                alu_of = (alu_a[W-1] != alu_b[W-1]) && (val_e[W-1] != alu_b[W-1]);
            end
            A_AND:   val_e = alu_b & alu_a;
            A_XOR:   val_e = alu_b ^ alu_a;
            default: ;
        endcase
    end

    // A faulting or halting instruction downstream must not see CC changed by a younger OPQ.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (e_q.icode == I_OPQ && !stat_blocks_cc(bus.m_stat_i)
                     && !stat_blocks_cc(bus.W_stat_i)) begin
            cc_q <= '{zf: (val_e == '0), sf: val_e[W-1], of: alu_of};
        end
    end

    assign e_cnd   = cond_eval(e_q.ifun, cc_q);
    assign e_dst_e = (e_q.icode == I_RRMOVQ && !e_cnd) ? R_NONE : e_q.dst_e;

    assign bus.D_icode_o = d_q.icode;
    assign bus.D_ifun_o  = d_q.ifun;
    assign bus.D_rA_o    = d_q.ra;
    assign bus.D_rB_o    = d_q.rb;
    assign bus.D_stat_o  = d_q.stat;
    assign bus.D_valC_o  = d_q.valc;
    assign bus.D_valP_o  = d_q.valp;
    assign bus.d_srcA_o  = src_a;
    assign bus.d_srcB_o  = src_b;
    assign bus.d_dstE_o  = dst_e;
    assign bus.d_dstM_o  = dst_m;
    assign bus.d_valA_o  = d_val_a;
    assign bus.d_valB_o  = d_val_b;
    assign bus.E_stat_o  = e_q.stat;
    assign bus.E_icode_o = e_q.icode;
    assign bus.E_ifun_o  = e_q.ifun;
    assign bus.E_srcA_o  = e_q.src_a;
    assign bus.E_srcB_o  = e_q.src_b;
    assign bus.E_dstE_o  = e_q.dst_e;
    assign bus.E_dstM_o  = e_q.dst_m;
    assign bus.E_valC_o  = e_q.valc;
    assign bus.E_valA_o  = e_q.vala;
    assign bus.E_valB_o  = e_q.valb;
    assign bus.e_Cnd_o   = e_cnd;
    assign bus.e_dstE_o  = e_dst_e;
    assign bus.e_valE_o  = val_e;

endmodule

// File: tb/tb_y86_decode_execute.sv
// Directed pipeline scenarios followed by randomized OPQ/JXX traffic against a reference model.
module tb_y86_decode_execute;
    import y86_decode_execute_pkg::*;

    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    y86_decode_execute_if #(.W(64), .N(4)) bus ();
    y86_decode_execute #(.W(64), .N(4)) dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        bus.f_icode_i = ic;  bus.f_ifun_i = fn;  bus.f_rA_i = ra;  bus.f_rB_i = rb;
        bus.f_valC_i  = vc;  bus.f_valP_i = vp;  bus.f_stat_i = 4'h1;
    endtask

    task automatic fb_idle();
        bus.M_dstE_i = 4'hF; bus.M_dstM_i = 4'hF; bus.M_valE_i = '0; bus.m_valM_i = '0;
        bus.W_dstE_i = 4'hF; bus.W_dstM_i = 4'hF; bus.W_valE_i = '0; bus.W_valM_i = '0;
        bus.m_stat_i = 4'h1; bus.W_stat_i = 4'h1;
    endtask

    // Reference ALU: OPQ semantics from two's-complement arithmetic on a 65-bit widening.
    function automatic logic [63:0] ref_op(input int fn, input logic [63:0] a,
                                           input logic [63:0] b, output logic ovf);
        logic signed [64:0] w;
        ovf = 1'b0;
        case (fn)
            0: begin w = $signed({a[63], a}) + $signed({b[63], b}); ovf = w[64] != w[63]; return w[63:0]; end
            1: begin w = $signed({b[63], b}) - $signed({a[63], a}); ovf = w[64] != w[63]; return w[63:0]; end
            2: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic ref_cond(input int fn, input logic zf, input logic sf, input logic of);
        case (fn)
            0: return 1'b1;
            1: return (sf != of) || zf;
            2: return sf != of;
            3: return zf;
            4: return !zf;
            5: return sf == of;
            6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic        mzf, msf, mof, ovf, exp_cnd;
        logic [63:0] a, b, exp_v, jp;
        logic [3:0]  ra, rb, jfn, ms, ws;
        int          fn, mode;
        logic [3:0]  stat_pool [8];
        stat_pool = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h5};

        rstn_i = 1'b1;
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        fb_idle();
        #1 rstn_i = 1'b0;
        tick();
        chk("rst D_icode", 64'(bus.D_icode_o), 64'h1);
        chk("rst D_rA", 64'(bus.D_rA_o), 64'hF);
        chk("rst E_icode", 64'(bus.E_icode_o), 64'h1);
        chk("rst E_dstE", 64'(bus.E_dstE_o), 64'hF);
        chk("rst d_valA", bus.d_valA_o, 64'h0);
        chk("rst e_valE", bus.e_valE_o, 64'h0);
        rstn_i = 1'b1;

        // Reset CC has ZF=1: JXX cond E must be taken; valA carries valP.
        fetch(4'h7, 4'h3, 4'hF, 4'hF, 64'h99, 64'h40);
        tick();
        chk("jxx d_valA=valP", bus.d_valA_o, 64'h40);
        chk("jxx d_srcA", 64'(bus.d_srcA_o), 64'hF);
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        chk("jxx E_valA", bus.E_valA_o, 64'h40);
        chk("rst cc cond E", 64'(bus.e_Cnd_o), 64'h1);

        fetch(4'h3, 4'h0, 4'hF, 4'h0, 64'h5, 64'h4A);
        tick();
        chk("irmovq d_dstE", 64'(bus.d_dstE_o), 64'h0);
        fetch(4'h6, 4'h0, 4'h0, 4'h3, '0, '0);
        tick();
        chk("irmovq e_valE", bus.e_valE_o, 64'h5);
        chk("irmovq e_dstE", 64'(bus.e_dstE_o), 64'h0);
        chk("fwd e->valA", bus.d_valA_o, 64'h5);
        chk("rf valB r3", bus.d_valB_o, 64'h0);
        tick();
        bus.M_dstE_i = 4'h0; bus.M_valE_i = 64'h5;
        #1;
        chk("fwd M_valE->valA", bus.d_valA_o, 64'h5);
        chk("fwd e->valB", bus.d_valB_o, 64'h5);
        bus.M_dstM_i = 4'h0; bus.m_valM_i = 64'h77;
        #1;
        chk("fwd m_valM over M_valE", bus.d_valA_o, 64'h77);
        fb_idle();
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        chk("opq add e_valE", bus.e_valE_o, 64'h5);

        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h7, '0);
        tick();
        fetch(4'h2, 4'h0, 4'h2, 4'h5, '0, '0);
        tick();
        bus.W_dstE_i = 4'h2; bus.W_valE_i = 64'h9;
        #1;
        chk("prio e over W", bus.d_valA_o, 64'h7);
        tick();
        chk("prio W only", bus.d_valA_o, 64'h9);
        chk("rrmovq e_valE", bus.e_valE_o, 64'h7);
        chk("rrmovq e_dstE", 64'(bus.e_dstE_o), 64'h5);
        fb_idle();
        #1;
        chk("rf r2 after W write", bus.d_valA_o, 64'h9);

        bus.W_dstM_i = 4'h3; bus.W_valM_i = 64'h1234;
        fetch(4'h6, 4'h0, 4'h2, 4'h3, '0, '0);
        tick();
        fb_idle();
        #1;
        chk("rf r3 read valB", bus.d_valB_o, 64'h1234);
        chk("rf r2 read valA", bus.d_valA_o, 64'h9);

        fetch(4'h6, 4'h1, 4'h7, 4'h8, '0, '0);
        tick();
        bus.W_dstE_i = 4'h7; bus.W_valE_i = 64'h3;
        bus.W_dstM_i = 4'h8; bus.W_valM_i = 64'h3;
        #1;
        chk("add 9+0x1234", bus.e_valE_o, 64'h123D);
        chk("sub d_valA", bus.d_valA_o, 64'h3);
        chk("sub d_valB", bus.d_valB_o, 64'h3);
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        fb_idle();
        chk("sub e_valE", bus.e_valE_o, 64'h0);
        chk("sub e_dstE", 64'(bus.e_dstE_o), 64'h8);
        chk("cond LE with ZF=0", 64'(bus.e_Cnd_o), 64'h0);
        fetch(4'h7, 4'h3, 4'hF, 4'hF, '0, '0);
        tick();
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        chk("ZF set by sub", 64'(bus.e_Cnd_o), 64'h1);

        fetch(4'h6, 4'h0, 4'h7, 4'h8, '0, '0);
        tick();
        fetch(4'h7, 4'h3, 4'hF, 4'hF, '0, '0);
        tick();
        chk("add 3+3", bus.e_valE_o, 64'h6);
        bus.m_stat_i = 4'h3;
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        bus.m_stat_i = 4'h1;
        chk("CC held on m_stat ADR", 64'(bus.e_Cnd_o), 64'h1);

        fetch(4'h2, 4'h2, 4'h7, 4'h9, '0, '0);
        tick();
        fetch(4'hA, 4'h0, 4'h7, 4'hF, '0, '0);
        tick();
        chk("cmovl e_Cnd", 64'(bus.e_Cnd_o), 64'h0);
        chk("cmovl e_dstE", 64'(bus.e_dstE_o), 64'hF);
        chk("cmovl e_valE", bus.e_valE_o, 64'h3);
        bus.W_dstE_i = 4'h4; bus.W_valE_i = 64'h100;
        #1;
        chk("pushq d_valB", bus.d_valB_o, 64'h100);
        chk("pushq d_dstE", 64'(bus.d_dstE_o), 64'h4);
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        fb_idle();
        chk("pushq e_valE", bus.e_valE_o, 64'hF8);
        chk("pushq e_dstE", 64'(bus.e_dstE_o), 64'h4);

        bus.W_dstE_i = 4'h6; bus.W_valE_i = 64'hAAAA;
        bus.W_dstM_i = 4'h6; bus.W_valM_i = 64'hBBBB;
        fetch(4'hB, 4'h0, 4'h6, 4'hF, '0, '0);
        tick();
        fb_idle();
        #1;
        chk("popq d_srcA", 64'(bus.d_srcA_o), 64'h4);
        chk("popq d_dstM", 64'(bus.d_dstM_o), 64'h6);
        chk("popq d_valB", bus.d_valB_o, 64'h100);
        fetch(4'h6, 4'h3, 4'h6, 4'h6, '0, '0);
        tick();
        chk("popq e_valE", bus.e_valE_o, 64'h108);
        chk("W_valM wins same dst", bus.d_valA_o, 64'hBBBB);
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);

        // Second asynchronous reset mid-cycle, then confirm registers were cleared.
        tick();
        rstn_i = 1'b0;
        #3;
        rstn_i = 1'b1;
        chk("rst2 E_icode", 64'(bus.E_icode_o), 64'h1);
        fetch(4'h6, 4'h0, 4'h2, 4'h6, '0, '0);
        tick();
        chk("rst2 rf r2", bus.d_valA_o, 64'h0);
        chk("rst2 rf r6", bus.d_valB_o, 64'h0);
        fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
        tick();
        tick();
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;

        for (int it = 0; it < 24; it++) begin
            fn   = int'($urandom_range(0, 3));
            ra   = 4'($urandom_range(0, 14));
            rb   = 4'((int'(ra) + int'($urandom_range(1, 14))) % 15);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            mode = int'($urandom_range(0, 4));
            if (mode == 0) b = a;
            if (mode == 1) begin a = 64'h7FFF_FFFF_FFFF_FFFF; b[63] = 1'b0; end
            if (mode == 2) a = 64'h8000_0000_0000_0000;
            fetch(4'h6, 4'(fn), ra, rb, '0, '0);
            tick();
            bus.W_dstE_i = ra; bus.W_valE_i = a;
            bus.W_dstM_i = rb; bus.W_valM_i = b;
            #1;
            chk("rnd d_valA", bus.d_valA_o, a);
            chk("rnd d_valB", bus.d_valB_o, b);
            jfn = 4'($urandom_range(0, 15));
            jp  = {$urandom, $urandom};
            fetch(4'h7, jfn, 4'hF, 4'hF, '0, jp);
            tick();
            fb_idle();
            exp_v   = ref_op(fn, a, b, ovf);
            exp_cnd = ref_cond(fn, mzf, msf, mof);
            chk("rnd e_valE", bus.e_valE_o, exp_v);
            chk("rnd e_dstE", 64'(bus.e_dstE_o), 64'(rb));
            chk("rnd opq e_Cnd", 64'(bus.e_Cnd_o), 64'(exp_cnd));
            chk("rnd jxx d_valA", bus.d_valA_o, jp);
            ms = stat_pool[$urandom_range(0, 7)];
            ws = stat_pool[$urandom_range(0, 7)];
            bus.m_stat_i = ms;
            bus.W_stat_i = ws;
            fetch(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
            tick();
            if (!(ms inside {4'h2, 4'h3, 4'h4}) && !(ws inside {4'h2, 4'h3, 4'h4})) begin
                mzf = (exp_v == 64'h0);
                msf = exp_v[63];
                mof = ovf;
            end
            fb_idle();
            #1;
            chk("rnd jxx e_Cnd", 64'(bus.e_Cnd_o), 64'(ref_cond(int'(jfn), mzf, msf, mof)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
